// File: rtl/cpu_pkg.sv
// Shared core constants: register file geometry, opcodes and operand-usage decode.
// Decode and the register scoreboard both derive issue_use_a/use_b/writes from here.
package cpu_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned OP_W     = 4;

  localparam logic [OP_W-1:0] OP_SUB  = 4'd0;
  localparam logic [OP_W-1:0] OP_MOVL = 4'd8;
  localparam logic [OP_W-1:0] OP_MOVH = 4'd9;
  localparam logic [OP_W-1:0] OP_JMP  = 4'd14;
  localparam logic [OP_W-1:0] OP_MEM  = 4'd15;

  localparam logic MEM_LD = 1'b0;
  localparam logic MEM_ST = 1'b1;

  typedef struct packed {
    logic use_a;
    logic use_b;
    logic writes;
  } issue_ctrl_t;

  // Operand usage per opcode; movh merges into the old rt value, so it reads ra.
  function automatic issue_ctrl_t decode_ctrl(input logic [OP_W-1:0] op,
                                              input logic            mem_sub);
    issue_ctrl_t c;
    c = '0;
    case (op)
      OP_SUB: begin
        c.use_a  = 1'b1;
        c.use_b  = 1'b1;
        c.writes = 1'b1;
      end
      OP_MOVL: c.writes = 1'b1;
      OP_MOVH: begin
        c.use_a  = 1'b1;
        c.writes = 1'b1;
      end
      OP_JMP: begin
        c.use_a = 1'b1;
        c.use_b = 1'b1;
      end
      OP_MEM: begin
        c.use_a  = 1'b1;
        c.use_b  = (mem_sub == MEM_ST);
        c.writes = (mem_sub == MEM_LD);
      end
      default: begin
        c.use_a = 1'b1;
        c.use_b = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
// Simultaneous inc and dec cancel; dec at zero holds and flags underflow.
module sb_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_is_zero_c,
  output logic             o_is_max_c,
  output logic             o_underflow_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    o_is_zero_c   = (r_cnt == '0);
    o_is_max_c    = (r_cnt == CNT_MAX);
    o_underflow_c = i_dec & o_is_zero_c & ~i_clr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_is_max_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && !o_is_zero_c) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters for r1..r15,
// stalling decode while a read source or a saturated destination is outstanding.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W         = 3,
  parameter bit          RETIRE_BYPASS = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  input  logic [3:0]         issue_ra,
  input  logic [3:0]         issue_rb,
  input  logic               issue_use_a,
  input  logic               issue_use_b,
  input  logic               issue_writes,
  input  logic [3:0]         issue_rt,
  input  logic               retire_valid,
  input  logic [3:0]         retire_rt,
  input  logic               flush,
  output logic               stall,
  output logic               issue_fire,
  output logic [15:0]        busy_mask,
  output logic [CNT_W+3:0]   inflight,
  output logic               err_underflow
);

  localparam int unsigned SUM_W = CNT_W + 4;

  logic [CNT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_zero;
  logic [NUM_REGS-1:0] w_max;
  logic [NUM_REGS-1:1] w_uf;
  logic [NUM_REGS-1:1] w_inc_vec;
  logic [NUM_REGS-1:1] w_dec_vec;

  logic w_byp_a, w_byp_b;
  logic w_haz_a, w_haz_b, w_full;
  logic w_inc, w_dec, w_same;
  logic w_up, w_down;

  logic [SUM_W-1:0] r_inflight;
  logic             r_err;

  // r0 is hard-wired idle: never busy, never full.
  assign w_cnt[0] = '0;
  assign w_zero[0] = 1'b1;
  assign w_max[0]  = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    assign w_inc_vec[g] = w_inc & (issue_rt == REG_W'(g));
    assign w_dec_vec[g] = w_dec & (retire_rt == REG_W'(g));

    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_inc         (w_inc_vec[g]),
      .i_dec         (w_dec_vec[g]),
      .i_clr         (flush),
      .o_cnt         (w_cnt[g]),
      .o_is_zero_c   (w_zero[g]),
      .o_is_max_c    (w_max[g]),
      .o_underflow_c (w_uf[g])
    );
  end

  // Hazard detection and counter enables; bypass relies on register-file write-through.
  always_comb begin
    w_byp_a = RETIRE_BYPASS && retire_valid && (retire_rt == issue_ra)
              && (w_cnt[issue_ra] == CNT_W'(1));
    w_byp_b = RETIRE_BYPASS && retire_valid && (retire_rt == issue_rb)
              && (w_cnt[issue_rb] == CNT_W'(1));
    w_haz_a = issue_use_a && (issue_ra != '0) && !w_zero[issue_ra] && !w_byp_a;
    w_haz_b = issue_use_b && (issue_rb != '0) && !w_zero[issue_rb] && !w_byp_b;
    w_full  = issue_writes && (issue_rt != '0) && w_max[issue_rt];

    stall      = issue_valid & (w_haz_a | w_haz_b | w_full);
    issue_fire = issue_valid & ~stall & ~flush;

    w_inc  = issue_fire & issue_writes & (issue_rt != '0);
    w_dec  = retire_valid & (retire_rt != '0) & ~flush;
    w_same = (issue_rt == retire_rt);

    // Mirror the counter update rules so the running total tracks the counter sum.
    w_up   = w_inc & ~(w_dec & w_same) & ~w_max[issue_rt];
    w_down = w_dec & ~(w_inc & w_same) & ~w_zero[retire_rt];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (flush) begin
        r_inflight <= '0;
      end else begin
        r_inflight <= r_inflight + SUM_W'(w_up) - SUM_W'(w_down);
      end
      if (|w_uf) begin
        r_err <= 1'b1;
      end
    end
  end

  assign busy_mask     = ~w_zero;
  assign inflight      = r_inflight;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares. A second instance runs with RETIRE_BYPASS=1.
module tb_reg_scoreboard;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned IW    = CNT_W + 4;

  logic          clk;
  logic          rst_n;
  logic          issue_valid;
  logic [3:0]    issue_ra;
  logic [3:0]    issue_rb;
  logic          issue_use_a;
  logic          issue_use_b;
  logic          issue_writes;
  logic [3:0]    issue_rt;
  logic          retire_valid;
  logic [3:0]    retire_rt;
  logic          flush;

  logic          stall, issue_fire, err_underflow;
  logic [15:0]   busy_mask;
  logic [IW-1:0] inflight;
  logic          stall_b, fire_b, err_b;
  logic [15:0]   busy_b;
  logic [IW-1:0] infl_b;

  reg_scoreboard #(.CNT_W(CNT_W), .RETIRE_BYPASS(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ra(issue_ra),
    .issue_rb(issue_rb), .issue_use_a(issue_use_a), .issue_use_b(issue_use_b),
    .issue_writes(issue_writes), .issue_rt(issue_rt), .retire_valid(retire_valid),
    .retire_rt(retire_rt), .flush(flush), .stall(stall), .issue_fire(issue_fire),
    .busy_mask(busy_mask), .inflight(inflight), .err_underflow(err_underflow)
  );

  reg_scoreboard #(.CNT_W(CNT_W), .RETIRE_BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ra(issue_ra),
    .issue_rb(issue_rb), .issue_use_a(issue_use_a), .issue_use_b(issue_use_b),
    .issue_writes(issue_writes), .issue_rt(issue_rt), .retire_valid(retire_valid),
    .retire_rt(retire_rt), .flush(flush), .stall(stall_b), .issue_fire(fire_b),
    .busy_mask(busy_b), .inflight(infl_b), .err_underflow(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          stall;
    logic          fire;
    logic          stall_b;
    logic          fire_b;
    logic [15:0]   busy;
    logic [IW-1:0] infl;
    logic          err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
    end
  endtask

  // Monitor: compare one queued expectation per cycle, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      cmp(mon_e.name, "stall",      32'(stall),         32'(mon_e.stall));
      cmp(mon_e.name, "issue_fire", 32'(issue_fire),    32'(mon_e.fire));
      cmp(mon_e.name, "busy_mask",  32'(busy_mask),     32'(mon_e.busy));
      cmp(mon_e.name, "inflight",   32'(inflight),      32'(mon_e.infl));
      cmp(mon_e.name, "err",        32'(err_underflow), 32'(mon_e.err));
      cmp(mon_e.name, "byp_stall",  32'(stall_b),       32'(mon_e.stall_b));
      cmp(mon_e.name, "byp_fire",   32'(fire_b),        32'(mon_e.fire_b));
      cmp(mon_e.name, "byp_busy",   32'(busy_b),        32'(mon_e.busy));
      cmp(mon_e.name, "byp_infl",   32'(infl_b),        32'(mon_e.infl));
      cmp(mon_e.name, "byp_err",    32'(err_b),         32'(mon_e.err));
    end else if (done) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_ra     = 4'd0;
    issue_rb     = 4'd0;
    issue_use_a  = 1'b0;
    issue_use_b  = 1'b0;
    issue_writes = 1'b0;
    issue_rt     = 4'd0;
    retire_valid = 1'b0;
    retire_rt    = 4'd0;
  endtask

  task automatic issue(input logic [3:0] ra, input logic [3:0] rb, input logic ua,
                       input logic ub, input logic wr, input logic [3:0] rt);
    issue_valid  = 1'b1;
    issue_ra     = ra;
    issue_rb     = rb;
    issue_use_a  = ua;
    issue_use_b  = ub;
    issue_writes = wr;
    issue_rt     = rt;
  endtask

  task automatic retire(input logic [3:0] rt);
    retire_valid = 1'b1;
    retire_rt    = rt;
  endtask

  task automatic exp_byp(input string name, input logic st, input logic fi,
                         input logic st_b, input logic fi_b, input logic [15:0] busy,
                         input logic [IW-1:0] infl, input logic err);
    exp_t e;
    e.name = name; e.stall = st; e.fire = fi; e.stall_b = st_b; e.fire_b = fi_b;
    e.busy = busy; e.infl = infl; e.err = err;
    q.push_back(e);
  endtask

  task automatic exp(input string name, input logic st, input logic fi,
                     input logic [15:0] busy, input logic [IW-1:0] infl, input logic err);
    exp_byp(name, st, fi, st, fi, busy, infl, err);
  endtask

  initial begin
    idle();
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp("reset_idle", 1'b0, 1'b0, 16'h0000, IW'(0), 1'b0); tick();

    issue(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    exp("read_r3", 1'b0, 1'b1, 16'h0000, IW'(0), 1'b0); tick();

    issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5);
    exp("write_r5", 1'b0, 1'b1, 16'h0000, IW'(0), 1'b0); tick();

    issue(4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    exp("read_r5_haz", 1'b1, 1'b0, 16'h0020, IW'(1), 1'b0); tick();

    retire(4'd5);
    exp_byp("retire_r5", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, IW'(1), 1'b0); tick();

    retire_valid = 1'b0;
    exp("after_retire_r5", 1'b0, 1'b1, 16'h0000, IW'(0), 1'b0); tick();

    idle();
    for (int k = 0; k < 7; k++) begin
      issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2);
      exp("fill_r2", 1'b0, 1'b1, (k == 0) ? 16'h0000 : 16'h0004, IW'(k), 1'b0);
      tick();
    end
    exp("full_r2", 1'b1, 1'b0, 16'h0004, IW'(7), 1'b0); tick();

    idle();
    retire(4'd2);
    exp("retire_r2", 1'b0, 1'b0, 16'h0004, IW'(7), 1'b0); tick();

    issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2);
    retire(4'd2);
    exp("iss_ret_r2", 1'b0, 1'b1, 16'h0004, IW'(6), 1'b0); tick();

    idle();
    exp("net_zero_r2", 1'b0, 1'b0, 16'h0004, IW'(6), 1'b0); tick();

    flush = 1'b1;
    exp("flush_r2", 1'b0, 1'b0, 16'h0004, IW'(6), 1'b0); tick();
    flush = 1'b0;
    exp("after_flush_r2", 1'b0, 1'b0, 16'h0000, IW'(0), 1'b0); tick();

    for (int k = 0; k < 3; k++) begin
      issue(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0);
      retire(4'd0);
      exp("r0_traffic", 1'b0, 1'b1, 16'h0000, IW'(0), 1'b0);
      tick();
    end
    idle();
    exp("r0_idle", 1'b0, 1'b0, 16'h0000, IW'(0), 1'b0); tick();

    issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4);
    exp("w_r4a", 1'b0, 1'b1, 16'h0000, IW'(0), 1'b0); tick();
    exp("w_r4b", 1'b0, 1'b1, 16'h0010, IW'(1), 1'b0); tick();
    issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9);
    exp("w_r9", 1'b0, 1'b1, 16'h0010, IW'(2), 1'b0); tick();

    issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4);
    retire(4'd9);
    flush = 1'b1;
    exp("flush_mix", 1'b0, 1'b0, 16'h0210, IW'(3), 1'b0); tick();
    idle();
    flush = 1'b0;
    exp("post_flush_mix", 1'b0, 1'b0, 16'h0000, IW'(0), 1'b0); tick();

    retire(4'd7);
    exp("retire_r7_empty", 1'b0, 1'b0, 16'h0000, IW'(0), 1'b0); tick();
    idle();
    exp("underflow", 1'b0, 1'b0, 16'h0000, IW'(0), 1'b1); tick();
    exp("err_sticky", 1'b0, 1'b0, 16'h0000, IW'(0), 1'b1); tick();

    issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3);
    exp("w_r3a", 1'b0, 1'b1, 16'h0000, IW'(0), 1'b1); tick();
    exp("w_r3b", 1'b0, 1'b1, 16'h0008, IW'(1), 1'b1); tick();

    issue(4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0);
    exp("rb_haz", 1'b1, 1'b0, 16'h0008, IW'(2), 1'b1); tick();
    issue(4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0);
    exp("unused_src", 1'b0, 1'b1, 16'h0008, IW'(2), 1'b1); tick();

    issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3);
    rst_n = 1'b0;
    exp("reset_mid", 1'b0, 1'b1, 16'h0008, IW'(2), 1'b1); tick();
    rst_n = 1'b1;
    idle();
    exp("post_reset", 1'b0, 1'b0, 16'h0000, IW'(0), 1'b0); tick();

    done = 1'b1;
  end

endmodule
